// File: rtl/isa_types.sv
`default_nettype none
// ============================================================================
// Module      : isa_types (package)
// Description : Shared ISA-level types for the hart. Holds the data/address
//               width, register index type, access width encoding, the
//               load/store unit state encoding, the load/store funct3
//               constants and a helper that maps funct3 to an access
//               width plus the zero-extend flag.
// Revision    : 1.0 - initial release with load/store unit support
// ============================================================================
package isa_types;

    localparam int XLEN = 32;

    typedef logic [4:0] rv_reg_t;

    // Access width, shared by loads and stores
    typedef enum logic [1:0] {
        WIDTH_BYTE = 2'd0,
        WIDTH_HALF = 2'd1,
        WIDTH_WORD = 2'd2
    } write_width_t;

    typedef enum logic [1:0] {
        LSU_IDLE      = 2'd0,
        LSU_REQ       = 2'd1,
        LSU_WAIT_RESP = 2'd2,
        LSU_DONE      = 2'd3
    } lsu_state_t;

    // OPCODE_LOAD funct3
    localparam logic [2:0] C_FUNCT3_LB  = 3'b000;
    localparam logic [2:0] C_FUNCT3_LH  = 3'b001;
    localparam logic [2:0] C_FUNCT3_LW  = 3'b010;
    localparam logic [2:0] C_FUNCT3_LBU = 3'b100;
    localparam logic [2:0] C_FUNCT3_LHU = 3'b101;

    // OPCODE_STORE funct3
    localparam logic [2:0] C_FUNCT3_SB  = 3'b000;
    localparam logic [2:0] C_FUNCT3_SH  = 3'b001;
    localparam logic [2:0] C_FUNCT3_SW  = 3'b010;

    typedef struct packed {
        write_width_t width;
        logic         is_unsigned;
    } mem_access_t;

    // funct3[1:0] selects the width, funct3[2] selects zero-extension.
    // The unsigned flag is meaningless for stores and is ignored there.
    function automatic mem_access_t decode_mem_funct3(input logic [2:0] funct3);
        mem_access_t acc;
        acc.is_unsigned = funct3[2];
        case (funct3[1:0])
            2'b00:   acc.width = WIDTH_BYTE;
            2'b01:   acc.width = WIDTH_HALF;
            default: acc.width = WIDTH_WORD;
        endcase
        return acc;
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_store_unit_lane_format.sv
`default_nettype none
// ============================================================================
// Module      : lsu_lane_format
// Description : Purely combinational lane logic for the load/store unit.
//               Generates byte enables, replicates store data across lanes
//               and shifts/extends returned load data.
// Ports       : width        in  access width
//               is_unsigned  in  zero-extend loads when 1
//               addr_lo      in  aligned byte offset within the word
//               store_data   in  raw store data (low bits significant)
//               load_data    in  raw word from the bus
//               byte_en      out byte-lane enables
//               store_lanes  out lane-replicated store data
//               load_result  out shifted and extended load value
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_lane_format
    import isa_types::*;
(
    input  write_width_t    width,
    input  logic            is_unsigned,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] store_data,
    input  logic [XLEN-1:0] load_data,
    output logic [3:0]      byte_en,
    output logic [XLEN-1:0] store_lanes,
    output logic [XLEN-1:0] load_result
);

    logic [XLEN-1:0] w_shifted;
    logic            w_sign_byte;
    logic            w_sign_half;

    // Bring the addressed byte/halfword down to bit 0
    assign w_shifted   = load_data >> {addr_lo, 3'b000};
    assign w_sign_byte = ~is_unsigned & w_shifted[7];
    assign w_sign_half = ~is_unsigned & w_shifted[15];

    always_comb begin
        byte_en     = 4'b1111;
        store_lanes = store_data;
        load_result = w_shifted;
        case (width)
            WIDTH_BYTE: begin
                byte_en     = 4'b0001 << addr_lo;
                store_lanes = {4{store_data[7:0]}};
                load_result = {{(XLEN-8){w_sign_byte}}, w_shifted[7:0]};
            end
            WIDTH_HALF: begin
                byte_en     = 4'b0011 << {addr_lo[1], 1'b0};
                store_lanes = {2{store_data[15:0]}};
                load_result = {{(XLEN-16){w_sign_half}}, w_shifted[15:0]};
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Memory-access stage. Accepts one decoded load/store at a
//               time, issues a single word-aligned bus access with byte
//               enables and lane steering, and returns the extended load
//               result for writeback.
// Macro       : LSU_MISALIGNED_TRAP_EN - when defined, misaligned halfword
//               and word accesses raise fault instead of touching the bus.
//               When undefined the low address bits are forced aligned.
// Ports       : clk, rst_n (sync, active-low)
//               req_*   decode-side valid/ready request
//               mem_*   data bus request/grant/response
//               done_valid, wb_valid, wb_rd, wb_data, fault  retire side
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit
    import isa_types::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_is_store,
    input  write_width_t    req_width,
    input  logic            req_unsigned,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    input  rv_reg_t         req_rd,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [3:0]      mem_be,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            done_valid,
    output logic            wb_valid,
    output rv_reg_t         wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            fault
);

    lsu_state_t      r_state;
    lsu_state_t      w_state_next;

    // Captured request
    logic            r_is_store;
    write_width_t    r_width;
    logic            r_unsigned;
    logic [1:0]      r_addr_lo;
    rv_reg_t         r_rd;

    // Bus-side registers: held steady for the whole REQ phase
    logic [XLEN-1:0] r_mem_addr;
    logic [3:0]      r_mem_be;
    logic [XLEN-1:0] r_mem_wdata;

    logic [XLEN-1:0] r_wb_data;
    rv_reg_t         r_wb_rd;

    logic            w_accept;
    logic [1:0]      w_req_lo;
    logic            w_misaligned;
    logic            w_trapped;

    write_width_t    w_fmt_width;
    logic            w_fmt_unsigned;
    logic [1:0]      w_fmt_lo;
    logic [3:0]      w_fmt_be;
    logic [XLEN-1:0] w_fmt_wdata;
    logic [XLEN-1:0] w_fmt_rdata;

    assign w_accept = (r_state == LSU_IDLE) && req_valid;

    // Drop offset bits that a naturally aligned access of this width cannot
    // carry. With the trap enabled such requests never reach the bus, so
    // forcing alignment unconditionally is harmless in both builds.
    always_comb begin
        w_req_lo = req_addr[1:0];
        case (req_width)
            WIDTH_HALF: w_req_lo = {req_addr[1], 1'b0};
            WIDTH_BYTE: w_req_lo = req_addr[1:0];
            default:    w_req_lo = 2'b00;
        endcase
    end

`ifdef LSU_MISALIGNED_TRAP_EN
    logic r_fault;

    always_comb begin
        w_misaligned = 1'b0;
        case (req_width)
            WIDTH_HALF: w_misaligned = req_addr[0];
            WIDTH_BYTE: w_misaligned = 1'b0;
            default:    w_misaligned = (req_addr[1:0] != 2'b00);
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fault <= 1'b0;
        end else if (w_accept) begin
            r_fault <= w_misaligned;
        end
    end

    assign w_trapped = r_fault;
`else
    assign w_misaligned = 1'b0;
    assign w_trapped    = 1'b0;
`endif

    // The formatter sees the live request while idle (to build the bus
    // image at acceptance) and the captured request afterwards (to format
    // the returning load data).
    assign w_fmt_width    = (r_state == LSU_IDLE) ? req_width    : r_width;
    assign w_fmt_unsigned = (r_state == LSU_IDLE) ? req_unsigned : r_unsigned;
    assign w_fmt_lo       = (r_state == LSU_IDLE) ? w_req_lo     : r_addr_lo;

    lsu_lane_format u_lane_format (
        .width       (w_fmt_width),
        .is_unsigned (w_fmt_unsigned),
        .addr_lo     (w_fmt_lo),
        .store_data  (req_wdata),
        .load_data   (mem_rdata),
        .byte_en     (w_fmt_be),
        .store_lanes (w_fmt_wdata),
        .load_result (w_fmt_rdata)
    );

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_is_store  <= 1'b0;
            r_width     <= WIDTH_BYTE;
            r_unsigned  <= 1'b0;
            r_addr_lo   <= 2'b00;
            r_rd        <= '0;
            r_mem_addr  <= '0;
            r_mem_be    <= 4'b0000;
            r_mem_wdata <= '0;
            r_wb_rd     <= '0;
            r_wb_data   <= '0;
        end else begin
            if (w_accept) begin
                r_is_store <= req_is_store;
                r_width    <= req_width;
                r_unsigned <= req_unsigned;
                r_addr_lo  <= w_req_lo;
                r_rd       <= req_rd;
                // A trapped access leaves the bus image untouched
                if (!w_misaligned) begin
                    r_mem_addr  <= {req_addr[XLEN-1:2], 2'b00};
                    r_mem_be    <= w_fmt_be;
                    r_mem_wdata <= w_fmt_wdata;
                end
            end
            if ((r_state == LSU_WAIT_RESP) && mem_rvalid) begin
                r_wb_rd   <= r_rd;
                r_wb_data <= w_fmt_rdata;
            end
        end
    end

    assign mem_addr  = r_mem_addr;
    assign mem_be    = r_mem_be;
    assign mem_wdata = r_mem_wdata;
    assign wb_rd     = r_wb_rd;
    assign wb_data   = r_wb_data;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= LSU_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        req_ready    = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        done_valid   = 1'b0;
        wb_valid     = 1'b0;
        fault        = 1'b0;
        case (r_state)
            LSU_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_state_next = w_misaligned ? LSU_DONE : LSU_REQ;
                end
            end
            LSU_REQ: begin
                mem_req = 1'b1;
                mem_we  = r_is_store;
                if (mem_gnt) begin
                    w_state_next = r_is_store ? LSU_DONE : LSU_WAIT_RESP;
                end
            end
            LSU_WAIT_RESP: begin
                if (mem_rvalid) begin
                    w_state_next = LSU_DONE;
                end
            end
            LSU_DONE: begin
                done_valid   = 1'b1;
                wb_valid     = ~r_is_store & ~w_trapped;
                fault        = w_trapped;
                w_state_next = LSU_IDLE;
            end
            default: w_state_next = LSU_IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Self-checking bench for load_store_unit. Directed cases for
//               the documented corner cases followed by randomized accesses
//               with random grant stalls and response waits, compared to a
//               byte-level reference model. Honours LSU_MISALIGNED_TRAP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;
    import isa_types::*;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req_valid;
    logic         req_ready;
    logic         req_is_store;
    write_width_t req_width;
    logic         req_unsigned;
    logic [31:0]  req_addr;
    logic [31:0]  req_wdata;
    logic [4:0]   req_rd;
    logic         mem_req;
    logic         mem_we;
    logic [31:0]  mem_addr;
    logic [3:0]   mem_be;
    logic [31:0]  mem_wdata;
    logic         mem_gnt;
    logic         mem_rvalid;
    logic [31:0]  mem_rdata;
    logic         done_valid;
    logic         wb_valid;
    logic [4:0]   wb_rd;
    logic [31:0]  wb_data;
    logic         fault;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_is_store (req_is_store),
        .req_width    (req_width),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_rd       (req_rd),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_be       (mem_be),
        .mem_wdata    (mem_wdata),
        .mem_gnt      (mem_gnt),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata),
        .done_valid   (done_valid),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .fault        (fault)
    );

    int total = 0;
    int bad   = 0;

    // Last writeback the unit should be holding
    logic [31:0] model_wb_data = '0;
    logic [4:0]  model_wb_rd   = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int nbytes(input int w);
        return (w == 0) ? 1 : ((w == 1) ? 2 : 4);
    endfunction

    function automatic int eff_offset(input int w, input logic [31:0] addr);
        int off;
        off = int'(addr[1:0]);
        return off - (off % nbytes(w));
    endfunction

    function automatic bit misaligned(input int w, input logic [31:0] addr);
`ifdef LSU_MISALIGNED_TRAP_EN
        return (int'(addr[1:0]) % nbytes(w)) != 0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [3:0] exp_be(input int w, input logic [31:0] addr);
        logic [3:0] be = '0;
        for (int i = 0; i < nbytes(w); i++) be[eff_offset(w, addr) + i] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] exp_wdata(input int w, input logic [31:0] d);
        logic [31:0] v = '0;
        for (int lane = 0; lane < 4; lane++) v[8*lane +: 8] = d[8*(lane % nbytes(w)) +: 8];
        return v;
    endfunction

    function automatic logic [31:0] exp_load(input int w, input bit uns, input logic [31:0] addr,
                                             input logic [31:0] rd);
        logic [31:0] v = '0;
        int n;
        int off;
        n   = nbytes(w);
        off = eff_offset(w, addr);
        for (int i = 0; i < n; i++) v[8*i +: 8] = rd[8*(off + i) +: 8];
        if (!uns && n < 4 && v[8*n-1]) begin
            for (int j = 8*n; j < 32; j++) v[j] = 1'b1;
        end
        return v;
    endfunction

    // One complete access; inputs driven and outputs sampled on negedges.
    task automatic do_access(input string tag, input bit st, input int w, input bit uns,
                             input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd,
                             input logic [31:0] rdata, input int gnt_stall, input int rv_wait);
        @(negedge clk);
        check_eq({tag, ".ready"}, {31'b0, req_ready}, 32'd1);
        check_eq({tag, ".idle_done"}, {31'b0, done_valid}, 32'd0);
        req_valid    = 1'b1;
        req_is_store = st;
        req_width    = write_width_t'(w[1:0]);
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
        req_rd       = rd;
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
        if (misaligned(w, addr)) begin
            check_eq({tag, ".trap_done"},  {31'b0, done_valid}, 32'd1);
            check_eq({tag, ".trap_fault"}, {31'b0, fault},      32'd1);
            check_eq({tag, ".trap_wb"},    {31'b0, wb_valid},   32'd0);
            check_eq({tag, ".trap_req"},   {31'b0, mem_req},    32'd0);
            return;
        end
        for (int s = 0; s <= gnt_stall; s++) begin
            check_eq({tag, ".mem_req"},  {31'b0, mem_req},   32'd1);
            check_eq({tag, ".mem_we"},   {31'b0, mem_we},    {31'b0, st});
            check_eq({tag, ".mem_addr"}, mem_addr,           {addr[31:2], 2'b00});
            check_eq({tag, ".mem_be"},   {28'b0, mem_be},    {28'b0, exp_be(w, addr)});
            if (st) check_eq({tag, ".mem_wdata"}, mem_wdata, exp_wdata(w, wd));
            check_eq({tag, ".busy"},     {31'b0, req_ready}, 32'd0);
            mem_gnt = (s == gnt_stall);
            @(negedge clk);
        end
        mem_gnt = 1'b0;
        if (!st) begin
            for (int r = 0; r <= rv_wait; r++) begin
                check_eq({tag, ".wait_req"},  {31'b0, mem_req},    32'd0);
                check_eq({tag, ".wait_done"}, {31'b0, done_valid}, 32'd0);
                mem_rvalid = (r == rv_wait);
                mem_rdata  = (r == rv_wait) ? rdata : $urandom;
                @(negedge clk);
            end
            mem_rvalid    = 1'b0;
            model_wb_data = exp_load(w, uns, addr, rdata);
            model_wb_rd   = rd;
        end
        check_eq({tag, ".done"},     {31'b0, done_valid}, 32'd1);
        check_eq({tag, ".wb_valid"}, {31'b0, wb_valid},   {31'b0, ~st});
        check_eq({tag, ".fault"},    {31'b0, fault},      32'd0);
        check_eq({tag, ".done_req"}, {31'b0, mem_req},    32'd0);
        check_eq({tag, ".wb_rd"},    {27'b0, wb_rd},      {27'b0, model_wb_rd});
        check_eq({tag, ".wb_data"},  wb_data,             model_wb_data);
    endtask

    initial begin
        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_is_store = 1'b0;
        req_width    = WIDTH_BYTE;
        req_unsigned = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        req_rd       = '0;
        mem_gnt      = 1'b0;
        mem_rvalid   = 1'b0;
        mem_rdata    = '0;

        repeat (2) @(negedge clk);
        check_eq("rst.ready",    {31'b0, req_ready},  32'd1);
        check_eq("rst.mem_req",  {31'b0, mem_req},    32'd0);
        check_eq("rst.mem_we",   {31'b0, mem_we},     32'd0);
        check_eq("rst.mem_addr", mem_addr,            32'd0);
        check_eq("rst.mem_be",   {28'b0, mem_be},     32'd0);
        check_eq("rst.wdata",    mem_wdata,           32'd0);
        check_eq("rst.done",     {31'b0, done_valid}, 32'd0);
        check_eq("rst.wb_valid", {31'b0, wb_valid},   32'd0);
        check_eq("rst.wb_rd",    {27'b0, wb_rd},      32'd0);
        check_eq("rst.wb_data",  wb_data,             32'd0);
        check_eq("rst.fault",    {31'b0, fault},      32'd0);
        rst_n = 1'b1;

        // Directed cases
        do_access("lb",  1'b0, 0, 1'b0, 32'h1003, 32'h0, 5'd5, 32'h80AABBCC, 0, 0);
        check_eq("lb.const", wb_data, 32'hFFFFFF80);
        do_access("lhu", 1'b0, 1, 1'b1, 32'h2002, 32'h0, 5'd6, 32'h80011234, 0, 0);
        check_eq("lhu.const", wb_data, 32'h00008001);
        do_access("sb",  1'b1, 0, 1'b0, 32'h3001, 32'h000000A5, 5'd0, 32'h0, 0, 0);
        do_access("sw_stall", 1'b1, 2, 1'b0, 32'h5000, 32'hDEADBEEF, 5'd0, 32'h0, 3, 0);
        do_access("lw_mis", 1'b0, 2, 1'b0, 32'h4002, 32'h0, 5'd7, 32'hCAFEF00D, 0, 2);
        do_access("lb_x0", 1'b0, 0, 1'b1, 32'h6002, 32'h0, 5'd0, 32'h00FE0000, 1, 1);

        // Reset while waiting for a load response
        @(negedge clk);
        req_valid = 1'b1; req_is_store = 1'b0; req_width = WIDTH_WORD;
        req_addr = 32'h7000; req_rd = 5'd9;
        @(negedge clk);
        req_valid = 1'b0;
        mem_gnt   = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        rst_n   = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_wb_data = '0;
        model_wb_rd   = '0;
        check_eq("rstw.ready",   {31'b0, req_ready}, 32'd1);
        check_eq("rstw.mem_req", {31'b0, mem_req},   32'd0);
        check_eq("rstw.wb",      {31'b0, wb_valid},  32'd0);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h12345678;
        @(negedge clk);
        mem_rvalid = 1'b0;
        check_eq("rstw.late_done", {31'b0, done_valid}, 32'd0);
        check_eq("rstw.late_wb",   {31'b0, wb_valid},   32'd0);
        check_eq("rstw.wb_data",   wb_data,             32'd0);
        check_eq("rstw.ready2",    {31'b0, req_ready},  32'd1);

        // Randomized accesses
        for (int k = 0; k < 250; k++) begin
            do_access("rnd", 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)),
                      1'($urandom_range(0, 1)), $urandom, $urandom, 5'($urandom),
                      $urandom, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
# load_store_unit

Memory-access stage of the hart, directly downstream of instruction decode. It consumes decoded OPCODE_LOAD/OPCODE_STORE operations and issues one word-aligned access per instruction on the data bus, using byte enables and lane steering. For loads it produces the sign- or zero-extended result for register writeback. It handles one outstanding access at a time under a valid/ready handshake.

## Interface
- XLEN, 32 (isa_types::XLEN), data and address width; only 32 is supported.
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, synchronous, active-low
- req_valid  in  1  decode presents an access
- req_ready  out  1  unit can accept (high only in IDLE)
- req_is_store  in  1  1 = store, 0 = load
- req_width  in  write_width_t  byte/halfword/word
- req_unsigned  in  1  loads: zero-extend (LBU/LHU); ignored for stores
- req_addr  in  XLEN  effective byte address
- req_wdata  in  XLEN  store data (low bits significant)
- req_rd  in  rv_reg_t  load destination register
- mem_req  out  1  bus request, held until grant
- mem_we  out  1  write strobe
- mem_addr  out  XLEN  word address, bits [1:0] always 0
- mem_be  out  4  byte-lane enables
- mem_wdata  out  XLEN  lane-steered store data
- mem_gnt  in  1  bus accepted request this cycle
- mem_rvalid  in  1  load data valid
- mem_rdata  in  XLEN  load data
- done_valid  out  1  one-cycle pulse: access retired (load or store)
- wb_valid  out  1  one-cycle pulse: load result valid
- wb_rd  out  rv_reg_t  load destination
- wb_data  out  XLEN  extended load result
- fault  out  1  one-cycle pulse: misaligned access (0 when macro absent)

## Operation
- FSM states: IDLE, REQ, WAIT_RESP, DONE.
- IDLE: req_ready=1. Transition on req_valid: capture all req_* fields and go to REQ.
- REQ: mem_req=1, with mem_we/addr/be/wdata stable until mem_gnt. On gnt, a store goes to DONE and a load goes to WAIT_RESP.
- WAIT_RESP: on mem_rvalid, capture the formatted data and go to DONE. mem_rvalid arriving in the same cycle as gnt is not legal for this bus.
- DONE: pulse done_valid; for loads, also pulse wb_valid with wb_rd/wb_data. Return to IDLE.
- Byte enables (a = addr[1:0]): byte -> 4'b0001<<a; halfword -> 4'b0011<<{a[1],1'b0}; word -> 4'b1111.
- Store steering: byte data is replicated to all 4 lanes; halfword data is replicated to both halves; word data passes unchanged.
- Load formatting: rdata >> (8*a), then mask to width. If req_unsigned=0, sign-extend from bit 7 or bit 15.
- rd = x0: wb_valid still pulses with wb_rd=0; the register file discards the write.
- Outputs hold their last values outside their valid pulses; the only exception is mem_* strobes, which are low when not in REQ.

## Timing
- Reset values: state IDLE, req_ready=1, mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0, done_valid=0, wb_valid=0, wb_rd=0, wb_data=0, fault=0.
- Best-case load: accept at cycle N, mem_req at N+1 (gnt at N+1), rvalid at N+2, wb_valid at N+3. Best-case store: done_valid at N+2.
- Each gnt-stall cycle or rvalid-wait cycle adds one cycle of latency.
- Back-to-back operation: the next request can be accepted in the cycle after DONE, giving a throughput of one access per 3 (store) or 4 (load) cycles minimum.
- rst_n low at any edge forces IDLE next cycle and drops mem_req. Any in-flight response is ignored, and the bus owner must be reset together with this unit.

## Configuration
- LSU_MISALIGNED_TRAP_EN defined: halfword with a[0]=1, or word with a!=0, is checked at acceptance. The unit goes straight to DONE with no bus access, pulses fault together with done_valid, and wb_valid stays 0.
- LSU_MISALIGNED_TRAP_EN undefined: fault is tied to 0. The address low bits are forced aligned (halfword clears a[0]; word clears a[1:0]) and the access proceeds normally.

## Structure
- Add to isa_types: lsu_state_t enum; load/store funct3 constants (LB/LH/LW/LBU/LHU, SB/SH/SW); a function mapping funct3 to write_width_t plus the unsigned flag. write_width_t is reused as the access width.
- Sub-module lsu_lane_format: purely combinational. It performs byte-enable generation, store replication, and load shift/extend, so it can be unit-tested in isolation.

## Test plan
- LB, addr=0x1003, rdata=0x80AABBCC -> mem_addr=0x1000, be=4'b1000, wb_data=0xFFFFFF80.
- LHU, addr=0x2002, rdata=0x8001_1234 -> be=4'b1100, wb_data=0x00008001.
- SB, addr=0x3001, wdata=0x000000A5 -> mem_we=1, be=4'b0010, mem_wdata=0xA5A5A5A5; done_valid 1 cycle after gnt; no wb_valid.
- SW with gnt stalled 3 cycles -> mem_req/addr/be/wdata stable for 4 cycles; req_ready=0 throughout.
- LW at addr=0x4002: with the macro -> fault+done_valid, no mem_req. Without the macro -> mem_addr=0x4000, be=4'b1111.
- rst_n low while in WAIT_RESP -> IDLE next cycle, no wb_valid, and a late rvalid is ignored.
